// File: rtl/mem_access_sequencer.sv
// ============================================================================
//  Module      : mem_access_sequencer
//  Description : Issues one data-memory bus access per MEM-stage instruction,
//                owns the MEM/WB stall, drains flushed accesses, times out.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        M_MemRead,
    input  logic        M_MemWrite,
    input  logic        M_Flush,
    input  logic        M_Stall_Ext,
    input  logic [31:0] M_Address,
    input  logic [31:0] M_WriteData,
    input  logic [3:0]  M_ByteEn,
    input  logic [31:0] DataMem_In,
    input  logic        DataMem_Ready,
    output logic        DataMem_Read,
    output logic [3:0]  DataMem_Write,
    output logic [29:0] DataMem_Address,
    output logic [31:0] DataMem_Out,
    output logic [31:0] M_ReadData,
    output logic        M_MemStall,
    output logic        WB_Stall,
    output logic        M_BusError
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_HOLD   = 2'd2;
    localparam logic [1:0] c_DRAIN  = 2'd3;

    localparam logic       c_TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic        r_read;
    logic [3:0]  r_write;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_data;
    logic [7:0]  r_cnt;

    logic        w_req;
    logic        w_busy;
    logic        w_timeout;
    logic [7:0]  w_cnt_next;
    logic        w_unused_addr;

    assign w_unused_addr = ^M_Address[1:0];

    assign w_req      = (M_MemRead | M_MemWrite) & ~M_Flush;
    assign w_busy     = (r_state == c_ACCESS) | (r_state == c_DRAIN);
    // Ready always wins over an expiring timeout in the same cycle
    assign w_timeout  = c_TO_EN & w_busy & ~DataMem_Ready & (r_cnt == c_TO_LAST);
    assign w_cnt_next = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    assign DataMem_Read    = r_read;
    assign DataMem_Write   = r_write;
    assign DataMem_Address = r_addr;
    assign DataMem_Out     = r_wdata;
    assign M_BusError      = w_timeout;
    assign WB_Stall        = M_MemStall;

    always_comb begin
        M_MemStall = 1'b0;
        M_ReadData = 32'h0;
        case (r_state)
            c_IDLE: begin
                M_MemStall = w_req;
            end
            c_ACCESS: begin
                if (DataMem_Ready) begin
                    if (!M_Flush) begin
                        M_ReadData = DataMem_In;
                    end
                end else if (!w_timeout && !M_Flush) begin
                    M_MemStall = 1'b1;
                end
            end
            c_HOLD: begin
                M_ReadData = r_data;
            end
            c_DRAIN: begin
                M_MemStall = w_req;
            end
            default: begin
                M_MemStall = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_read  <= 1'b0;
            r_write <= 4'h0;
            r_addr  <= 30'h0;
            r_wdata <= 32'h0;
            r_data  <= 32'h0;
            r_cnt   <= 8'h0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        r_state <= c_ACCESS;
                        r_read  <= M_MemRead;
                        r_write <= M_MemWrite ? M_ByteEn : 4'h0;
                        r_addr  <= M_Address[31:2];
                        r_wdata <= M_WriteData;
                        r_cnt   <= 8'h0;
                    end
                end
                c_ACCESS: begin
                    if (DataMem_Ready || w_timeout) begin
                        r_read  <= 1'b0;
                        r_write <= 4'h0;
                        r_addr  <= 30'h0;
                        r_wdata <= 32'h0;
                        r_cnt   <= 8'h0;
                        if (DataMem_Ready && !M_Flush) begin
                            r_data <= DataMem_In;
                        end
                        // A flushed instruction never parks in HOLD
                        if (DataMem_Ready && M_Stall_Ext && !M_Flush) begin
                            r_state <= c_HOLD;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (M_Flush) begin
                            r_state <= c_DRAIN;
                        end
                    end
                end
                c_HOLD: begin
                    if (!M_Stall_Ext || M_Flush) begin
                        r_state <= c_IDLE;
                        r_data  <= 32'h0;
                    end
                end
                c_DRAIN: begin
                    if (DataMem_Ready || w_timeout) begin
                        r_state <= c_IDLE;
                        r_read  <= 1'b0;
                        r_write <= 4'h0;
                        r_addr  <= 30'h0;
                        r_wdata <= 32'h0;
                        r_cnt   <= 8'h0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
// ============================================================================
//  Module      : tb_mem_access_sequencer
//  Description : Directed, table-driven bench for mem_access_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr, fl, ext, rdy;
    logic [31:0] addr, wd, din;
    logic [3:0]  be;

    logic        d_rd, d_stall, d_wbstall, d_berr;
    logic [3:0]  d_wr;
    logic [29:0] d_addr;
    logic [31:0] d_out, d_rdata;

    logic        t_rd, t_stall, t_wbstall, t_berr;
    logic [3:0]  t_wr;
    logic [29:0] t_addr;
    logic [31:0] t_out, t_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_sequencer dut (
        .clock(clk), .reset(rst), .M_MemRead(rd), .M_MemWrite(wr), .M_Flush(fl),
        .M_Stall_Ext(ext), .M_Address(addr), .M_WriteData(wd), .M_ByteEn(be),
        .DataMem_In(din), .DataMem_Ready(rdy), .DataMem_Read(d_rd),
        .DataMem_Write(d_wr), .DataMem_Address(d_addr), .DataMem_Out(d_out),
        .M_ReadData(d_rdata), .M_MemStall(d_stall), .WB_Stall(d_wbstall),
        .M_BusError(d_berr)
    );

    mem_access_sequencer #(.TIMEOUT(4)) dut_to (
        .clock(clk), .reset(rst), .M_MemRead(rd), .M_MemWrite(wr), .M_Flush(fl),
        .M_Stall_Ext(ext), .M_Address(addr), .M_WriteData(wd), .M_ByteEn(be),
        .DataMem_In(din), .DataMem_Ready(rdy), .DataMem_Read(t_rd),
        .DataMem_Write(t_wr), .DataMem_Address(t_addr), .DataMem_Out(t_out),
        .M_ReadData(t_rdata), .M_MemStall(t_stall), .WB_Stall(t_wbstall),
        .M_BusError(t_berr)
    );

    typedef struct packed {
        logic [95:0] name;
        logic        rst, rd, wr, fl, ext;
        logic [31:0] addr, wd;
        logic [3:0]  be;
        logic [31:0] din;
        logic        rdy;
        logic        e_rd;
        logic [3:0]  e_wr;
        logic [29:0] e_addr;
        logic [31:0] e_out, e_rdata;
        logic        e_stall, e_berr;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic [95:0] n,
                                input logic r, input logic r_d, input logic w_r,
                                input logic f, input logic x,
                                input logic [31:0] a, input logic [31:0] w,
                                input logic [3:0] b, input logic [31:0] di,
                                input logic rd_y, input logic erd, input logic [3:0] ewr,
                                input logic [29:0] ea, input logic [31:0] eo,
                                input logic [31:0] erdata, input logic es, input logic eb);
        vec_t v;
        v.name = n; v.rst = r; v.rd = r_d; v.wr = w_r; v.fl = f; v.ext = x;
        v.addr = a; v.wd = w; v.be = b; v.din = di; v.rdy = rd_y;
        v.e_rd = erd; v.e_wr = ewr; v.e_addr = ea; v.e_out = eo;
        v.e_rdata = erdata; v.e_stall = es; v.e_berr = eb;
        return v;
    endfunction

    task automatic set_in(input logic r, input logic r_d, input logic w_r, input logic f,
                          input logic x, input logic [31:0] a, input logic [31:0] w,
                          input logic [3:0] b, input logic [31:0] di, input logic rd_y);
        rst = r; rd = r_d; wr = w_r; fl = f; ext = x;
        addr = a; wd = w; be = b; din = di; rdy = rd_y;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick; tick;

        //             name          rst rd wr fl ext addr       wdata      be  din          rdy | rd wr      addr      out         rdata        st be
        tv.push_back(mk("reset_idle", 0, 0, 0, 0, 0, 32'h0,     32'h0,     0,  32'h0,       0,  0, 4'h0, 30'h0,    32'h0,      32'h0,       0, 0));
        tv.push_back(mk("t1_issue",   0, 1, 0, 0, 0, 32'h1000,  32'h0,     0,  32'h0,       0,  0, 4'h0, 30'h0,    32'h0,      32'h0,       1, 0));
        tv.push_back(mk("t1_acc1",    0, 1, 0, 0, 0, 32'h1000,  32'h0,     0,  32'h0,       0,  1, 4'h0, 30'h400,  32'h0,      32'h0,       1, 0));
        tv.push_back(mk("t1_acc2",    0, 1, 0, 0, 0, 32'h1000,  32'h0,     0,  32'h0,       0,  1, 4'h0, 30'h400,  32'h0,      32'h0,       1, 0));
        tv.push_back(mk("t1_ready",   0, 1, 0, 0, 0, 32'h1000,  32'h0,     0,  32'hDEADBEEF,1,  1, 4'h0, 30'h400,  32'h0,      32'hDEADBEEF,0, 0));
        tv.push_back(mk("t1_stray",   0, 0, 0, 0, 0, 32'h0,     32'h0,     0,  32'h12345678,1,  0, 4'h0, 30'h0,    32'h0,      32'h0,       0, 0));
        tv.push_back(mk("t2_issue",   0, 0, 1, 0, 0, 32'h2004,  32'hABCD,  3,  32'h0,       0,  0, 4'h0, 30'h0,    32'h0,      32'h0,       1, 0));
        tv.push_back(mk("t2_ready",   0, 0, 1, 0, 0, 32'h2004,  32'hABCD,  3,  32'h0,       1,  0, 4'h3, 30'h801,  32'hABCD,   32'h0,       0, 0));
        tv.push_back(mk("t2_after",   0, 0, 0, 0, 0, 32'h0,     32'h0,     0,  32'h0,       0,  0, 4'h0, 30'h0,    32'h0,      32'h0,       0, 0));
        tv.push_back(mk("t3_issue",   0, 1, 0, 0, 0, 32'h3000,  32'h0,     0,  32'h0,       0,  0, 4'h0, 30'h0,    32'h0,      32'h0,       1, 0));
        tv.push_back(mk("t3_ready",   0, 1, 0, 0, 1, 32'h3000,  32'h0,     0,  32'hCAFEF00D,1,  1, 4'h0, 30'hC00,  32'h0,      32'hCAFEF00D,0, 0));
        tv.push_back(mk("t3_hold1",   0, 1, 0, 0, 1, 32'h3000,  32'h0,     0,  32'h0,       0,  0, 4'h0, 30'h0,    32'h0,      32'hCAFEF00D,0, 0));
        tv.push_back(mk("t3_hold2",   0, 1, 0, 0, 1, 32'h3000,  32'h0,     0,  32'h99999999,1,  0, 4'h0, 30'h0,    32'h0,      32'hCAFEF00D,0, 0));
        tv.push_back(mk("t3_hold3",   0, 1, 0, 0, 1, 32'h3000,  32'h0,     0,  32'h0,       0,  0, 4'h0, 30'h0,    32'h0,      32'hCAFEF00D,0, 0));
        tv.push_back(mk("t3_release", 0, 1, 0, 0, 0, 32'h3000,  32'h0,     0,  32'h0,       0,  0, 4'h0, 30'h0,    32'h0,      32'hCAFEF00D,0, 0));
        tv.push_back(mk("t3_next",    0, 0, 0, 0, 0, 32'h0,     32'h0,     0,  32'h0,       0,  0, 4'h0, 30'h0,    32'h0,      32'h0,       0, 0));
        tv.push_back(mk("t4_issue",   0, 1, 0, 0, 0, 32'h4000,  32'h0,     0,  32'h0,       0,  0, 4'h0, 30'h0,    32'h0,      32'h0,       1, 0));
        tv.push_back(mk("t4_acc1",    0, 1, 0, 0, 0, 32'h4000,  32'h0,     0,  32'h0,       0,  1, 4'h0, 30'h1000, 32'h0,      32'h0,       1, 0));
        tv.push_back(mk("t4_flush",   0, 1, 0, 1, 0, 32'h4000,  32'h0,     0,  32'h0,       0,  1, 4'h0, 30'h1000, 32'h0,      32'h0,       0, 0));
        tv.push_back(mk("t4_drain1",  0, 1, 0, 0, 0, 32'h5000,  32'h0,     0,  32'h0,       0,  1, 4'h0, 30'h1000, 32'h0,      32'h0,       1, 0));
        tv.push_back(mk("t4_drain2",  0, 1, 0, 0, 0, 32'h5000,  32'h0,     0,  32'h0,       0,  1, 4'h0, 30'h1000, 32'h0,      32'h0,       1, 0));
        tv.push_back(mk("t4_drainrdy",0, 1, 0, 0, 0, 32'h5000,  32'h0,     0,  32'h11111111,1,  1, 4'h0, 30'h1000, 32'h0,      32'h0,       1, 0));
        tv.push_back(mk("t4_reissue", 0, 1, 0, 0, 0, 32'h5000,  32'h0,     0,  32'h0,       0,  0, 4'h0, 30'h0,    32'h0,      32'h0,       1, 0));
        tv.push_back(mk("t4_newrdy",  0, 1, 0, 0, 0, 32'h5000,  32'h0,     0,  32'h55AA55AA,1,  1, 4'h0, 30'h1400, 32'h0,      32'h55AA55AA,0, 0));
        tv.push_back(mk("t4_after",   0, 0, 0, 0, 0, 32'h0,     32'h0,     0,  32'h0,       0,  0, 4'h0, 30'h0,    32'h0,      32'h0,       0, 0));
        tv.push_back(mk("t6_issue",   0, 1, 0, 0, 0, 32'h6000,  32'h0,     0,  32'h0,       0,  0, 4'h0, 30'h0,    32'h0,      32'h0,       1, 0));
        tv.push_back(mk("t6_acc1",    0, 1, 0, 0, 0, 32'h6000,  32'h0,     0,  32'h0,       0,  1, 4'h0, 30'h1800, 32'h0,      32'h0,       1, 0));
        tv.push_back(mk("t6_reset",   1, 1, 0, 0, 0, 32'h6000,  32'h0,     0,  32'h0,       0,  1, 4'h0, 30'h1800, 32'h0,      32'h0,       1, 0));
        tv.push_back(mk("t6_stray",   0, 0, 0, 0, 0, 32'h0,     32'h0,     0,  32'hFFFFFFFF,1,  0, 4'h0, 30'h0,    32'h0,      32'h0,       0, 0));
        tv.push_back(mk("t6_quiet",   0, 0, 0, 0, 0, 32'h0,     32'h0,     0,  32'h0,       0,  0, 4'h0, 30'h0,    32'h0,      32'h0,       0, 0));

        foreach (tv[i]) begin
            vec_t v;
            string n;
            v = tv[i];
            n = $sformatf("%0s", v.name);
            set_in(v.rst, v.rd, v.wr, v.fl, v.ext, v.addr, v.wd, v.be, v.din, v.rdy);
            #4;
            chk({n, ".read"},   {31'h0, d_rd},      {31'h0, v.e_rd});
            chk({n, ".write"},  {28'h0, d_wr},      {28'h0, v.e_wr});
            chk({n, ".addr"},   {2'b0, d_addr},     {2'b0, v.e_addr});
            chk({n, ".out"},    d_out,              v.e_out);
            chk({n, ".rdata"},  d_rdata,            v.e_rdata);
            chk({n, ".stall"},  {31'h0, d_stall},   {31'h0, v.e_stall});
            chk({n, ".wbstall"},{31'h0, d_wbstall}, {31'h0, v.e_stall});
            chk({n, ".berr"},   {31'h0, d_berr},    {31'h0, v.e_berr});
            tick;
        end

        // Ready coinciding with Flush (and Ext): data discarded, back to IDLE, not HOLD
        set_in(0, 1, 0, 0, 0, 32'h8000, 0, 0, 0, 0);
        #4; chk("rf_issue.stall", {31'h0, d_stall}, 32'h1);
        tick;
        set_in(0, 1, 0, 1, 1, 32'h8000, 0, 0, 32'h77777777, 1);
        #4; chk("rf_ready.read", {31'h0, d_rd}, 32'h1);
        chk("rf_ready.addr", {2'b0, d_addr}, 32'h2000);
        tick;
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        #4; chk("rf_after.rdata", d_rdata, 32'h0);
        chk("rf_after.read", {31'h0, d_rd}, 32'h0);
        chk("rf_after.stall", {31'h0, d_stall}, 32'h0);
        tick;

        // Timeout on the TIMEOUT=4 instance: error pulse on the 4th ACCESS cycle
        set_in(0, 1, 0, 0, 0, 32'h7000, 0, 0, 0, 0);
        #4; chk("to_issue.stall", {31'h0, t_stall}, 32'h1);
        tick;
        for (int c = 0; c < 3; c++) begin
            #4;
            chk($sformatf("to_wait%0d.read", c), {31'h0, t_rd}, 32'h1);
            chk($sformatf("to_wait%0d.addr", c), {2'b0, t_addr}, 32'h1C00);
            chk($sformatf("to_wait%0d.stall", c), {31'h0, t_stall}, 32'h1);
            chk($sformatf("to_wait%0d.berr", c), {31'h0, t_berr}, 32'h0);
            tick;
        end
        #4;
        chk("to_expire.berr", {31'h0, t_berr}, 32'h1);
        chk("to_expire.stall", {31'h0, t_stall}, 32'h0);
        chk("to_expire.wbstall", {31'h0, t_wbstall}, 32'h0);
        chk("to_expire.rdata", t_rdata, 32'h0);
        chk("to_expire.read", {31'h0, t_rd}, 32'h1);
        tick;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        chk("to_after.read", {31'h0, t_rd}, 32'h0);
        chk("to_after.berr", {31'h0, t_berr}, 32'h0);
        chk("to_after.stall", {31'h0, t_stall}, 32'h0);
        chk("to_after.addr", {2'b0, t_addr}, 32'h0);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
